// File: rtl/uart_tx_queue_if.sv
// Host-side write port of uart_tx_queue: byte strobe in, queue status and overflow flag out.
interface uart_tx_queue_if #(
  parameter int DEPTH = 4
) ();
  logic                   wr;
  logic [7:0]             wr_data;
  logic                   full;
  logic [$clog2(DEPTH):0] level;
  logic                   ovf;
  logic                   ovf_clr;

  modport master (output wr, wr_data, ovf_clr, input full, level, ovf);
  modport slave  (input wr, wr_data, ovf_clr, output full, level, ovf);
endinterface

// File: rtl/uart_tx_queue.sv
// Byte transmit FIFO feeding an LSB-first 8N1 serializer on the UART TX pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_queue #(
  parameter int CLOCK_HZ = 100_000,
  parameter int BAUD     = 1_000,
  parameter int DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_queue_if.slave host,
  output logic           busy,
  output logic           tx
);

  localparam int BIT_CYC = CLOCK_HZ / BAUD;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q, level_nxt;
  logic             full_q, ovf_q;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift;
  logic             push, pop, shift_en, bit_end, has_data, tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic             par_bit;
`endif

  // Full is sampled before any pop, so a write while full is always dropped.
  assign push       = host.wr && !full_q;
  assign has_data   = (level_q != '0);
  assign bit_end    = (cnt == CNT_LAST);
  assign busy       = (state != S_IDLE);
  assign host.full  = full_q;
  assign host.level = level_q;
  assign host.ovf   = ovf_q;

  always_comb begin
    level_nxt = level_q;
    if (push && !pop) begin
      level_nxt = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_nxt = level_q - LVL_ONE;
    end
  end

  // tx is registered from the current state, so the line lags the state by one cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_ONE;
    bit_idx_nxt = bit_idx;
    pop         = 1'b0;
    shift_en    = 1'b0;
    tx_nxt      = 1'b1;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (has_data) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        tx_nxt = shift[0];
        if (bit_end) begin
          cnt_nxt     = '0;
          shift_en    = 1'b1;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_nxt = par_bit;
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (has_data) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level_q <= level_nxt;
      full_q  <= (level_nxt == LVL_FULL);
      if (host.wr && full_q) begin
        ovf_q <= 1'b1;
      end else if (host.ovf_clr) begin
        ovf_q <= 1'b0;
      end
      tx <= tx_nxt;
    end
  end

  // Storage and shifter carry no reset; control state alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host.wr_data;
    if (pop) begin
      shift <= mem[rd_ptr];
    end else if (shift_en) begin
      shift <= {1'b0, shift[7:1]};
    end
`ifdef UART_TX_PARITY_EN
    if (pop) par_bit <= ^mem[rd_ptr];
`endif
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized and directed bench for uart_tx_queue against a frame-level queue model and a bench UART receiver.
module tb_uart_tx_queue;
  localparam int CLOCK_HZ = 100_000;
  localparam int BAUD     = 1_000;
  localparam int DEPTH    = 4;
  localparam int BC       = CLOCK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy, tx;

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_queue #(.CLOCK_HZ(CLOCK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (bus),
    .busy (busy),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a byte queue plus "cycles since the current frame was popped".
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] rxq[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = '0;
  bit         m_ovf = 1'b0;
  bit         m_tx = 1'b1;
  bit         line_v, pop_v;
  int         pre_v;

  function automatic bit line_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (NB == 11 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_t = 0;
      m_ovf = 1'b0;
      m_tx = 1'b1;
    end else begin
      line_v = m_active ? line_bit(m_cur, m_t / BC) : 1'b1;
      pre_v  = mq.size();
      pop_v  = (pre_v > 0) && (!m_active || m_t == FL - 1);
      if (m_active) begin
        if (m_t == FL - 1) m_active = 1'b0;
        else m_t++;
      end
      if (pop_v) begin
        m_cur = mq.pop_front();
        sent.push_back(m_cur);
        m_active = 1'b1;
        m_t = 0;
      end
      if (bus.wr) begin
        if (pre_v == DEPTH) m_ovf = 1'b1;
        else mq.push_back(bus.wr_data);
      end
      if (!(bus.wr && pre_v == DEPTH) && bus.ovf_clr) m_ovf = 1'b0;
      m_tx = line_v;
    end
  end

  always @(negedge clk) begin
    check("tx", 32'(tx), 32'(m_tx));
    check("busy", 32'(busy), 32'(m_active));
    check("level", 32'(bus.level), 32'(mq.size()));
    check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    check("ovf", 32'(bus.ovf), 32'(m_ovf));
  end

  // Bench UART receiver sampling mid-bit.
  bit         rx_on = 1'b0;
  int         rx_t = 0;
  int         rx_k;
  logic [7:0] rx_b = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on = 1'b1;
        rx_t = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % BC == BC / 2) begin
        rx_k = rx_t / BC;
        if (rx_k == 0) begin
          check("rx_start", 32'(tx), 32'd0);
        end else if (rx_k <= 8) begin
          rx_b[rx_k-1] = tx;
        end else if (rx_k == NB - 1) begin
          check("rx_stop", 32'(tx), 32'd1);
          rxq.push_back(rx_b);
          rx_on = 1'b0;
        end else begin
          check("rx_parity", 32'(tx), 32'(^rx_b));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write1(input logic [7:0] d);
    @(negedge clk);
    bus.wr = 1'b1;
    bus.wr_data = d;
  endtask

  task automatic end_wr();
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  // Checks tx at the middle of frame position pos; at is cycles already waited since the write.
  task automatic probe_pos(input string name, input int pos, input bit exp, inout int at);
    cycles(BC * pos + BC / 2 + 1 - at);
    at = BC * pos + BC / 2 + 1;
    check(name, 32'(tx), 32'(exp));
  endtask

  bit e41 [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] burst3 [3] = '{8'h04, 8'h55, 8'h0A};

  initial begin
    int at;
    bus.wr = 1'b0;
    bus.wr_data = '0;
    bus.ovf_clr = 1'b0;
    #1 rst_n = 1'b0;
    cycles(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    rst_n = 1'b1;
    cycles(500);
    check("idle_busy", 32'(busy), 32'd0);

    // Single 0x41 frame, pinned bit by bit.
    write1(8'h41);
    end_wr();
    at = 0;
    for (int k = 0; k < 9; k++) probe_pos("lit_41_bit", k, e41[k], at);
    if (NB == 10) probe_pos("lit_41_stop", 9, 1'b1, at);
    cycles(FL - at);
    check("lit_41_busy_end", 32'(busy), 32'd1);
    cycles(1);
    check("lit_41_busy_off", 32'(busy), 32'd0);
    cycles(50);
    check("lit_41_rx_n", 32'(rxq.size()), 32'd1);
    if (rxq.size() == 1) check("lit_41_rx", 32'(rxq[0]), 32'h41);
    rxq.delete();

    // Three consecutive writes go out back-to-back.
    for (int i = 0; i < 3; i++) write1(burst3[i]);
    end_wr();
    cycles(3 * FL + 100);
    check("lit_b3_rx_n", 32'(rxq.size()), 32'd3);
    for (int i = 0; i < 3 && i < rxq.size(); i++) check("lit_b3_rx", 32'(rxq[i]), 32'(burst3[i]));
    rxq.delete();

    // Overflow: six writes while 0x10 is in flight.
    for (int i = 0; i < 6; i++) write1(8'h10 + 8'(i));
    end_wr();
    check("lit_ovf_level", 32'(bus.level), 32'd4);
    check("lit_ovf_full", 32'(bus.full), 32'd1);
    check("lit_ovf_set", 32'(bus.ovf), 32'd1);
    @(negedge clk) bus.ovf_clr = 1'b1;
    @(negedge clk) bus.ovf_clr = 1'b0;
    check("lit_ovf_clr", 32'(bus.ovf), 32'd0);
    cycles(5 * FL + 100);
    check("lit_ovf_rx_n", 32'(rxq.size()), 32'd5);
    for (int i = 0; i < 5 && i < rxq.size(); i++) check("lit_ovf_rx", 32'(rxq[i]), 32'h10 + 32'(i));
    rxq.delete();

    // Reset during data bit 3 with two bytes still queued.
    write1(8'hA0);
    write1(8'hA1);
    write1(8'hA2);
    end_wr();
    check("lit_rst_pre_level", 32'(bus.level), 32'd2);
    cycles(450);
    check("lit_rst_pre_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("lit_rst_tx", 32'(tx), 32'd1);
    check("lit_rst_busy", 32'(busy), 32'd0);
    check("lit_rst_level", 32'(bus.level), 32'd0);
    check("lit_rst_full", 32'(bus.full), 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(1500);
    check("lit_rst_rx_n", 32'(rxq.size()), 32'd0);
    check("lit_rst_tx_idle", 32'(tx), 32'd1);

    // Random traffic: sparse phase, then a dense phase that overflows.
    sent.delete();
    rxq.delete();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 6000; i++) begin
        @(negedge clk);
        bus.wr = ($urandom_range(0, (ph == 0) ? 899 : 59) == 0);
        bus.wr_data = 8'($urandom);
        bus.ovf_clr = ($urandom_range(0, 199) == 0);
      end
    end
    @(negedge clk);
    bus.wr = 1'b0;
    bus.ovf_clr = 1'b0;
    cycles((DEPTH + 1) * FL + 200);
    check("rand_rx_n", 32'(rxq.size()), 32'(sent.size()));
    for (int i = 0; i < rxq.size() && i < sent.size(); i++) check("rand_rx", 32'(rxq[i]), 32'(sent[i]));
    rxq.delete();

`ifdef UART_TX_PARITY_EN
    write1(8'h07);
    end_wr();
    at = 0;
    probe_pos("lit_par07", 9, 1'b1, at);
    probe_pos("lit_par07_stop", 10, 1'b1, at);
    cycles(FL - at);
    check("lit_par_busy_end", 32'(busy), 32'd1);
    cycles(1);
    check("lit_par_busy_off", 32'(busy), 32'd0);
    write1(8'h03);
    end_wr();
    at = 0;
    probe_pos("lit_par03", 9, 1'b0, at);
    cycles(FL + 100);
    check("lit_par_rx_n", 32'(rxq.size()), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
